// File: rtl/mips_pkg.sv
// Shared register-file constants for the ID/WB integration of the MIPS core.
// Pure declarations; no logic, no latency.
package mips_pkg;
    localparam int NUM_REGS   = 32;
    localparam int REG_ADDR_W = 5;
    localparam int ZERO_REG   = 0;
    localparam int CNT_W      = 2;
    localparam int PERF_W     = 16;
endpackage

// File: rtl/sb_counter.sv
// Per-register pending-write counter: one-edge update, saturating in both directions.
// inc at max and dec at zero are ignored so the count can never wrap.
module sb_counter #(
    parameter int CNT_W = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc,
    input  logic dec,
    output logic max,
    output logic nonzero
);
    logic [CNT_W-1:0] cnt;
    logic             inc_ok;
    logic             dec_ok;

    assign max     = &cnt;
    assign nonzero = |cnt;
    assign inc_ok  = inc && !max;
    assign dec_ok  = dec && nonzero;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
        end else begin
            case ({inc_ok, dec_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end
endmodule

// File: rtl/wb_scoreboard.sv
// Register-write scoreboard: stalls ID on RAW or full counter, retires on the WB write port.
// Stall/Issue are combinational from ID inputs and registered counters; tracking updates in one edge.
module wb_scoreboard
    import mips_pkg::*;
#(
    parameter int NUM_REGS   = mips_pkg::NUM_REGS,
    parameter int REG_ADDR_W = mips_pkg::REG_ADDR_W,
    parameter int CNT_W      = mips_pkg::CNT_W,
    parameter int PERF_W     = mips_pkg::PERF_W
) (
    input  logic                  Clk,
    input  logic                  Rst_n,
    input  logic                  ID_Valid,
    input  logic [REG_ADDR_W-1:0] ID_Rs,
    input  logic [REG_ADDR_W-1:0] ID_Rt,
    input  logic                  ID_UsesRs,
    input  logic                  ID_UsesRt,
    input  logic                  ID_RegWrite,
    input  logic [REG_ADDR_W-1:0] ID_WriteReg,
    input  logic                  WB_RegWrite,
    input  logic [REG_ADDR_W-1:0] WB_WriteReg,
    output logic                  Stall,
    output logic                  Issue,
    output logic [NUM_REGS-1:0]   Busy,
    output logic                  Underflow,
    output logic [PERF_W-1:0]     StallCycles
);
    localparam logic [REG_ADDR_W-1:0] ZERO = REG_ADDR_W'(ZERO_REG);

    logic [NUM_REGS-1:0] nz;
    logic [NUM_REGS-1:0] mx;
    logic raw_s, raw_t, full;
    logic wb_live;

    // Register 0 is hardwired: never pending, never full.
    assign nz[0] = 1'b0;
    assign mx[0] = 1'b0;

    for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
        sb_counter #(.CNT_W(CNT_W)) u_cnt (
            .clk     (Clk),
            .rst_n   (Rst_n),
            .inc     (Issue && ID_RegWrite && (ID_WriteReg == REG_ADDR_W'(r))),
            .dec     (WB_RegWrite && (WB_WriteReg == REG_ADDR_W'(r))),
            .max     (mx[r]),
            .nonzero (nz[r])
        );
    end

    // No WB bypass: a retire in this cycle only unblocks ID from the next cycle.
    assign raw_s   = ID_UsesRs && (ID_Rs != ZERO) && nz[ID_Rs];
    assign raw_t   = ID_UsesRt && (ID_Rt != ZERO) && nz[ID_Rt];
    assign full    = ID_RegWrite && (ID_WriteReg != ZERO) && mx[ID_WriteReg];
    assign Stall   = ID_Valid && (raw_s || raw_t || full);
    assign Issue   = ID_Valid && !Stall;
    assign Busy    = nz;
    assign wb_live = WB_RegWrite && (WB_WriteReg != ZERO);

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            Underflow   <= 1'b0;
            StallCycles <= '0;
        end else begin
            if (wb_live && !nz[WB_WriteReg]) begin
                Underflow <= 1'b1;
            end
            if (Stall && !(&StallCycles)) begin
                StallCycles <= StallCycles + 1'b1;
            end
        end
    end
endmodule
